// File: rtl/fp_intermediate_wb_arbiter_pkg.sv
// Shared FP writeback types: packet layout used by producers and the
// intermediate writeback arbiter, plus a small index-width helper.
package fpu_types;
  localparam int FP_WB_ID_W      = 3;
  localparam int FP_WB_PAYLOAD_W = 100;

  typedef logic [FP_WB_ID_W-1:0] id_t;

  typedef struct packed {
    id_t                        id;
    logic [FP_WB_PAYLOAD_W-1:0] payload;
  } fp_wb_packet_t;

  // Index width that never collapses to zero bits for a single source.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fp_intermediate_wb_arbiter_if.sv
// Bus between the intermediate-result producers, the arbiter and the
// normalise/round stage.
interface fp_intermediate_wb_arbiter_if
  import fpu_types::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int ID_W      = FP_WB_ID_W,
  parameter int PAYLOAD_W = FP_WB_PAYLOAD_W,
  parameter int SRC_W     = idx_width(NUM_SRC)
);
  logic [NUM_SRC-1:0]           src_done;
  logic [NUM_SRC*ID_W-1:0]      src_id;
  logic [NUM_SRC*PAYLOAD_W-1:0] src_payload;
  logic [NUM_SRC-1:0]           src_ack;
  logic                         out_valid;
  logic [ID_W-1:0]              out_id;
  logic [PAYLOAD_W-1:0]         out_payload;
  logic [SRC_W-1:0]             out_src;
  logic                         out_ready;

  modport master (
    output src_done, src_id, src_payload, out_ready,
    input  src_ack, out_valid, out_id, out_payload, out_src
  );

  modport slave (
    input  src_done, src_id, src_payload, out_ready,
    output src_ack, out_valid, out_id, out_payload, out_src
  );
endinterface

// File: rtl/fp_intermediate_wb_arbiter_rr_grant.sv
// Combinational round-robin pick: rotate requests so ptr is bit 0, take the
// lowest set bit, then map the offset back to a source index.
module fp_rr_grant
  import fpu_types::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               any_req
);
  function automatic int wrap(input int v);
    return (v >= NUM_SRC) ? v - NUM_SRC : v;
  endfunction

  logic [NUM_SRC-1:0] rot;
  int                 sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_rot
      assign rot[gi] = req[wrap(int'(ptr) + gi)];
    end
  endgenerate

  always_comb begin
    sel = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rot[k]) sel = k;
    end
  end

  assign grant   = PTR_W'(wrap(int'(ptr) + sel));
  assign any_req = |req;
endmodule

// File: rtl/fp_intermediate_wb_arbiter.sv
// Round-robin serialiser of intermediate FP results into a single registered
// output slot feeding the normalise/round stage.
module fp_intermediate_wb_arbiter
  import fpu_types::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int ID_W      = FP_WB_ID_W,
  parameter int PAYLOAD_W = FP_WB_PAYLOAD_W
) (
  input logic                         clk,
  input logic                         rst,
  fp_intermediate_wb_arbiter_if.slave bus
);
  localparam int SRC_W = idx_width(NUM_SRC);

  logic [ID_W-1:0]      src_id_arr      [NUM_SRC];
  logic [PAYLOAD_W-1:0] src_payload_arr [NUM_SRC];
  logic [NUM_SRC-1:0]   ack;
  logic [SRC_W-1:0]     grant;
  logic [SRC_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic                 any_req;
  logic                 advance;
  logic                 out_valid_reg;
  logic [ID_W-1:0]      out_id_reg;
  logic [PAYLOAD_W-1:0] out_payload_reg;
  logic [SRC_W-1:0]     out_src_reg;

  assign advance = ~out_valid_reg | bus.out_ready;

  fp_rr_grant #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (SRC_W)
  ) u_grant (
    .req     (bus.src_done),
    .ptr     (rr_ptr_reg),
    .grant   (grant),
    .any_req (any_req)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_id_arr[gi]      = bus.src_id[gi*ID_W +: ID_W];
      assign src_payload_arr[gi] = bus.src_payload[gi*PAYLOAD_W +: PAYLOAD_W];
      // Ack is the load strobe: it only fires when the slot actually takes the result.
      assign ack[gi] = ~rst & advance & any_req & (grant == SRC_W'(gi));
    end
  endgenerate

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (advance && any_req) begin
      rr_ptr_next = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (advance) out_valid_reg <= any_req;
    end
  end

  // Data side carries no reset; it is ignored whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (advance && any_req) begin
      out_id_reg      <= src_id_arr[grant];
      out_payload_reg <= src_payload_arr[grant];
      out_src_reg     <= grant;
    end
  end

  assign bus.src_ack     = ack;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_id      = out_id_reg;
  assign bus.out_payload = out_payload_reg;
  assign bus.out_src     = out_src_reg;
endmodule

// File: tb/tb_fp_intermediate_wb_arbiter.sv
// Bench for the intermediate writeback arbiter: directed scenarios plus a
// long random run against a behavioural round-robin model and scoreboard.
module tb_fp_intermediate_wb_arbiter;
  import fpu_types::*;

  localparam int N   = 4;
  localparam int IDW = FP_WB_ID_W;
  localparam int PW  = FP_WB_PAYLOAD_W;

  typedef struct packed {
    logic [1:0]    src;
    fp_wb_packet_t pkt;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   d_done = '0;
  logic [IDW-1:0] d_id [N];
  logic [PW-1:0]  d_pl [N];
  logic           d_ready = 1'b1;
  logic [N-1:0]   ack_seen = '0;
  bit             verbose = 1'b1;

  int n_assert = 0;
  int n_fail   = 0;

  fp_intermediate_wb_arbiter_if #(.NUM_SRC(N), .ID_W(IDW), .PAYLOAD_W(PW)) bus ();

  fp_intermediate_wb_arbiter #(.NUM_SRC(N), .ID_W(IDW), .PAYLOAD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb begin
    bus.src_done    = d_done;
    bus.out_ready   = d_ready;
    bus.src_id      = '0;
    bus.src_payload = '0;
    for (int i = 0; i < N; i++) begin
      bus.src_id[i*IDW +: IDW]   = d_id[i];
      bus.src_payload[i*PW +: PW] = d_pl[i];
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin choice from the rules: first pending source at or after ptr.
  function automatic int pick(input logic [N-1:0] done, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (done[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  bit             m_valid = 1'b0;
  logic [IDW-1:0] m_id;
  logic [PW-1:0]  m_pl;
  int             m_src = 0;
  int             m_ptr = 0;
  sb_t            sb [$];
  int             wait_cnt [N];

  // Compare process: inputs are stable from the falling edge, so check here
  // and then step the model to the state the next rising edge produces.
  always begin : cmp_proc
    int           g;
    bit           adv;
    logic [N-1:0] exp_ack;
    sb_t          e;
    @(negedge clk);
    #2;
    g       = pick(d_done, m_ptr);
    adv     = !m_valid || d_ready;
    exp_ack = '0;
    if (!rst && adv && g >= 0) exp_ack[g] = 1'b1;
    check("ack", bus.src_ack, exp_ack);
    check("valid", bus.out_valid, m_valid);
    if (m_valid) begin
      check("out_id", bus.out_id, m_id);
      check("out_payload", bus.out_payload, m_pl);
      check("out_src", bus.out_src, m_src);
    end
    if (rst) begin
      sb.delete();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 0, 1);
        end else begin
          check("sb_id", bus.out_id, sb[0].pkt.id);
          check("sb_payload", bus.out_payload, sb[0].pkt.payload);
          check("sb_src", bus.out_src, sb[0].src);
          if (d_ready) void'(sb.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.src_ack[i] === 1'b1) begin
          e.src         = 2'(i);
          e.pkt.id      = d_id[i];
          e.pkt.payload = d_pl[i];
          sb.push_back(e);
          if (verbose) $display("txn: ack src %0d id %0d payload %0h", i, d_id[i], d_pl[i]);
        end
        if (!d_done[i] || bus.src_ack[i] === 1'b1) begin
          wait_cnt[i] = 0;
        end else if (adv) begin
          wait_cnt[i]++;
          check("fairness", wait_cnt[i] < N, 1);
        end
      end
    end
    ack_seen = bus.src_ack;
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
    end else if (adv) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_id  = d_id[g];
        m_pl  = d_pl[g];
        m_src = g;
        m_ptr = (g + 1) % N;
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    logic [127:0] r;
    for (int i = 0; i < N; i++) begin
      d_id[i] = '0;
      d_pl[i] = '0;
    end

    // Reset held, then idle after release.
    step(); settle();
    check("t1_ack_in_rst", bus.src_ack, 0);
    step(); rst = 1'b0; settle();
    check("t1_rr_ptr", dut.rr_ptr_reg, 0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      settle();
      check("t1_valid", bus.out_valid, 0);
      check("t1_ack", bus.src_ack, 0);
    end

    // All four sources pending: strict rotation one per cycle.
    for (int k = 0; k < 8; k++) begin
      step();
      d_done = 4'b1111;
      for (int i = 0; i < N; i++) begin
        d_id[i] = IDW'(i);
        d_pl[i] = PW'(100 * k + i);
      end
      settle();
      check("t2_ack", bus.src_ack, 1 << (k % 4));
      if (k > 0) begin
        check("t2_valid", bus.out_valid, 1);
        check("t2_out_src", bus.out_src, (k - 1) % 4);
        check("t2_out_id", bus.out_id, (k - 1) % 4);
      end
    end
    step(); d_done = '0; settle();
    check("t2_last_src", bus.out_src, 3);

    // Back-pressure with src 2 / id 5 held in the slot.
    step(); d_done = 4'b0100; d_id[2] = 3'd5; d_pl[2] = PW'(555); settle();
    check("t3_load_ack", bus.src_ack, 4'b0100);
    for (int c = 0; c < 3; c++) begin
      step(); d_done = 4'b0001; d_id[0] = 3'd6; d_pl[0] = PW'(666); d_ready = 1'b0; settle();
      check("t3_stall_ack", bus.src_ack, 0);
      check("t3_stall_id", bus.out_id, 5);
      check("t3_stall_src", bus.out_src, 2);
      check("t3_stall_valid", bus.out_valid, 1);
    end
    step(); d_ready = 1'b1; settle();
    check("t3_release_ack", bus.src_ack, 4'b0001);
    check("t3_release_id", bus.out_id, 5);
    step(); d_done = '0; settle();
    check("t3_next_src", bus.out_src, 0);
    check("t3_next_id", bus.out_id, 6);

    // Pointer wrap from 3 to 0.
    step(); d_done = 4'b0100; d_id[2] = 3'd1; settle();
    check("t4_setup_ack", bus.src_ack, 4'b0100);
    step(); d_done = 4'b1001; d_id[3] = 3'd3; d_id[0] = 3'd4; d_pl[0] = PW'(444); settle();
    check("t4_grant3", bus.src_ack, 4'b1000);
    step(); d_done = 4'b0001; settle();
    check("t4_grant0", bus.src_ack, 4'b0001);
    check("t4_ptr_wrapped", dut.rr_ptr_reg, 0);
    check("t4_src3_out", bus.out_src, 3);
    step(); d_done = '0; settle();
    check("t4_src0_out", bus.out_src, 0);
    check("t4_id_out", bus.out_id, 4);

    // Reset during a stall drops the held entry and re-homes the pointer.
    step(); d_done = 4'b0010; d_id[1] = 3'd2; settle();
    check("t5_ack1", bus.src_ack, 4'b0010);
    step(); d_ready = 1'b0; d_done = 4'b1100; d_id[2] = 3'd7; d_id[3] = 3'd1; settle();
    check("t5_stall_valid", bus.out_valid, 1);
    check("t5_stall_ack", bus.src_ack, 0);
    step(); rst = 1'b1; settle();
    check("t5_ack_in_rst", bus.src_ack, 0);
    step(); rst = 1'b0; d_ready = 1'b1; settle();
    check("t5_valid_after_rst", bus.out_valid, 0);
    check("t5_ptr_after_rst", dut.rr_ptr_reg, 0);
    check("t5_first_grant", bus.src_ack, 4'b0100);
    step(); d_done = 4'b1000; settle();
    check("t5_out_src", bus.out_src, 2);
    check("t5_out_id", bus.out_id, 7);
    check("t5_ack3", bus.src_ack, 4'b1000);
    step(); d_done = '0; settle();
    check("t5_out_src3", bus.out_src, 3);

    // Random traffic; producers hold results until acked.
    verbose = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!d_done[i] || ack_seen[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            r       = {$urandom, $urandom, $urandom, $urandom};
            d_done[i] = 1'b1;
            d_id[i] = IDW'($urandom);
            d_pl[i] = r[PW-1:0];
          end else begin
            d_done[i] = 1'b0;
          end
        end
      end
      d_ready = ($urandom_range(0, 3) != 0);
    end

    step(); d_done = '0; d_ready = 1'b1;
    repeat (4) step();
    settle();
    check("sb_drained", sb.size(), 0);
    check("final_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
